// File: rtl/spi_peripheral.sv
// spi_peripheral -- SPI peripheral (target) with an 8-bit TX holding register.
//
// All logic runs on i_clk. SCLK, CS_n and COPI are brought in through two-flop
// synchronizers. A third registered copy of SCLK and CS_n is used for edge
// detection. SPI modes 0..3 are supported. The mode is latched at frame start.
// Bytes move MSB first. Multi-byte frames run back to back while CS_n stays low.
//
// Ports:
//   i_clk, i_rst         system clock, asynchronous active-high reset
//   i_sclk, i_cs_n       SPI clock / chip select (asynchronous to i_clk)
//   i_copi, o_cipo       serial data in / out
//   i_mode[1:0]          {CPOL, CPHA}, latched in LOAD
//   i_tx_data/valid      byte for the holding register; accepted when o_tx_ready
//   o_tx_ready           holding register empty
//   o_rx_data/valid      last received byte, one-cycle valid pulse
//   o_busy               a frame is in progress
//
// Configuration macro: SPI_PERIPHERAL_CIPO_TRISTATE_EN
//   defined   -> o_cipo is high-Z in IDLE and during reset
//   undefined -> o_cipo drives 0 in IDLE and during reset
module spi_peripheral (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_copi,
    output logic       o_cipo,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sclk_q, cs_q;
    logic [1:0]  copi_q;
    logic [1:0]  mode_q, mode_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic        cipo_q, cipo_d;
    logic [7:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic samp_edge, shift_edge, tx_load, consume;
    logic [7:0] next_tx;

    // Synchronizers; index [2] is the extra copy used only for edge detection.
    // CS_n resets high and SCLK low, so no edge is seen on reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            copi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], i_sclk};
            cs_q   <= {cs_q[1:0], i_cs_n};
            copi_q <= {copi_q[0], i_copi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];

    // Sample on the rising edge when CPOL == CPHA (modes 0 and 3).
    assign samp_edge  = (mode_q[1] == mode_q[0]) ? sclk_rise : sclk_fall;
    assign shift_edge = (mode_q[1] == mode_q[0]) ? sclk_fall : sclk_rise;

    assign tx_load = i_tx_valid & ~hold_full_q;
    assign next_tx = hold_full_q ? hold_q : 8'h00;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            cnt_q       <= 3'd0;
            tx_sr_q     <= 8'h00;
            cipo_q      <= 1'b0;
            rx_sr_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            tx_sr_q     <= tx_sr_d;
            cipo_q      <= cipo_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        tx_sr_d    = tx_sr_q;
        cipo_d     = cipo_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        consume    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                mode_d  = i_mode;
                cnt_d   = 3'd0;
                consume = 1'b1;
                // CPHA=0 shows bit 7 right away. CPHA=1 waits for the leading edge.
                if (i_mode[0]) begin
                    tx_sr_d = next_tx;
                    cipo_d  = 1'b0;
                end else begin
                    tx_sr_d = {next_tx[6:0], 1'b0};
                    cipo_d  = next_tx[7];
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                if (samp_edge) begin
                    rx_sr_d = {rx_sr_q[6:0], copi_q[1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = {rx_sr_q[6:0], copi_q[1]};
                        rx_valid_d = 1'b1;
                        consume    = 1'b1;
                        if (mode_q[0]) begin
                            tx_sr_d = next_tx;
                        end else begin
                            tx_sr_d = {next_tx[6:0], 1'b0};
                            cipo_d  = next_tx[7];
                        end
                    end
                end else if (shift_edge && (mode_q[0] || cnt_q != 3'd0)) begin
                    // With CPHA=0, the trailing edge after the 8th sample is
                    // skipped. Bit 7 of the reloaded byte is already on the pin.
                    cipo_d  = tx_sr_q[7];
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        // A CS_n deassertion wins over everything and drops any partial byte.
        // It also leaves the holding register untouched.
        if (cs_rise) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            rx_data_d  = rx_data_q;
            rx_valid_d = 1'b0;
            consume    = 1'b0;
        end
    end

    // The consume path reads the old contents. A same-cycle load refills the register.
    always_comb begin
        hold_full_d = (hold_full_q & ~consume) | tx_load;
        hold_d      = tx_load ? i_tx_data : hold_q;
    end

    assign o_tx_ready = ~hold_full_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_busy     = (state_q != IDLE);

`ifdef SPI_PERIPHERAL_CIPO_TRISTATE_EN
    assign o_cipo = (state_q == IDLE) ? 1'bz : cipo_q;
`else
    assign o_cipo = (state_q == IDLE) ? 1'b0 : cipo_q;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed testbench for spi_peripheral. A behavioural SPI controller drives
// the bus at SCLK = i_clk/8. Expected bytes go into two queues. rxq holds the
// bytes the peripheral should receive. ctlq holds the bytes the controller
// should receive.
module tb_spi_peripheral;
    logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, copi = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    wire        cipo;
    logic       tx_ready, rx_valid, busy;
    logic [7:0] rx_data;

    int checks = 0, failures = 0, rx_pulses = 0;
    logic [7:0] rxq[$];
    logic [7:0] ctlq[$];
    localparam int H = 4;

`ifdef SPI_PERIPHERAL_CIPO_TRISTATE_EN
    localparam logic CIPO_IDLE = 1'bz;
`else
    localparam logic CIPO_IDLE = 1'b0;
`endif

    spi_peripheral dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_copi(copi),
        .o_cipo(cipo), .i_mode(mode), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Every received byte must match the next expected byte in rxq.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            logic [7:0] e;
            rx_pulses++;
            if (rxq.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL rx_unexpected observed=%h expected=none", rx_data);
            end else begin
                e = rxq.pop_front();
                chk("rx_data_pulse", rx_data, e);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int t = 0;
        while (tx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk1("tx_ready_wait", tx_ready, 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        ctlq.push_back(b);
    endtask

    task automatic frame_start(input logic [1:0] m);
        mode = m;
        sclk = m[1];
        clks(6);
        cs_n = 1'b0;
        clks(6);
    endtask

    task automatic frame_end();
        clks(H);
        cs_n = 1'b1;
        clks(6);
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (!mode[0]) begin
                copi = b[7-i];
                clks(H);
                r = {r[6:0], cipo};
                sclk = ~sclk;
                clks(H);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                copi = b[7-i];
                clks(H);
                r = {r[6:0], cipo};
                sclk = ~sclk;
                clks(H);
            end
        end
    endtask

    task automatic xfer_byte(input logic [7:0] b);
        logic [7:0] r, e;
        rxq.push_back(b);
        xfer_bits(b, 8, r);
        e = ctlq.pop_front();
        chk("ctl_rx", r, e);
    endtask

    initial begin
        int p;
        logic [7:0] junk;
        clks(3);
        rst = 1'b0;
        clks(2);
        chk1("rst_tx_ready", tx_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk1("rst_cipo", cipo, CIPO_IDLE);

        // Mode 0: tx 0xA5, rx 0x3C.
        push_tx(8'hA5);
        chk1("hold_full", tx_ready, 1'b0);
        frame_start(2'b00);
        chk1("busy_in_frame", busy, 1'b1);
        chk1("m0_first_bit", cipo, 1'b1);
        xfer_byte(8'h3C);
        frame_end();
        chk("m0_rx_data", rx_data, 8'h3C);
        chk("m0_pulses", rx_pulses, 1);
        chk1("m0_busy_after", busy, 1'b0);

        // Modes 1..3: tx 0x81, rx 0x7E. A CPHA=1 mode drives 0 until the leading edge.
        for (int m = 1; m < 4; m++) begin
            p = rx_pulses;
            push_tx(8'h81);
            frame_start(m[1:0]);
            chk1("mode_first_bit", cipo, m[0] ? 1'b0 : 1'b1);
            xfer_byte(8'h7E);
            frame_end();
            chk("mode_rx_data", rx_data, 8'h7E);
            chk("mode_pulses", rx_pulses, p + 1);
        end

        // Three-byte frame. The holding register is refilled while shifting.
        p = rx_pulses;
        push_tx(8'h11);
        frame_start(2'b00);
        push_tx(8'h22);
        xfer_byte(8'h01);
        push_tx(8'h33);
        xfer_byte(8'h02);
        xfer_byte(8'h03);
        frame_end();
        chk("multi_pulses", rx_pulses, p + 3);
        chk("multi_rx_last", rx_data, 8'h03);

        // Empty holding register: the controller should receive 0x00.
        frame_start(2'b00);
        ctlq.push_back(8'h00);
        xfer_byte(8'h55);
        frame_end();
        chk("empty_rx_data", rx_data, 8'h55);

        // Abort after 5 bits, then a clean 0xC3 frame.
        p = rx_pulses;
        frame_start(2'b00);
        xfer_bits(8'hFF, 5, junk);
        frame_end();
        chk("abort_pulses", rx_pulses, p);
        chk("abort_rx_hold", rx_data, 8'h55);
        push_tx(8'h5A);
        frame_start(2'b00);
        xfer_byte(8'hC3);
        frame_end();
        chk("after_abort_rx", rx_data, 8'hC3);

        // Reset mid-byte. Outputs must return to reset values immediately.
        push_tx(8'h99);
        frame_start(2'b00);
        junk = ctlq.pop_front();
        xfer_bits(8'h99, 4, junk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rx_data", rx_data, 8'h00);
        chk1("midrst_rx_valid", rx_valid, 1'b0);
        chk1("midrst_tx_ready", tx_ready, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_cipo", cipo, CIPO_IDLE);
        clks(2);
        cs_n = 1'b1;
        sclk = 1'b0;
        clks(2);
        rst = 1'b0;
        clks(6);
        push_tx(8'hE7);
        frame_start(2'b00);
        xfer_byte(8'h18);
        frame_end();
        chk("post_rst_rx", rx_data, 8'h18);

        chk("rxq_drained", rxq.size(), 0);
        chk("ctlq_drained", ctlq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
